hssaer_rx_arbiter: RTL and testbench

- Merges NCH hssaer_paer_rx channel outputs (dsize-bit events, src_rdy/dst_rdy handshake) into one int_dsize-bit event stream for the HPU RX FIFO, using round-robin arbitration.
- Tags each event with its channel ID and configured higher bits.
- Collects per-channel error flags into sticky, maskable status with a single interrupt line.
- Sits between the per-link RX wrappers and the RX FIFO/AXI register bank.

---
 rtl/hpu_rx_pkg.sv | 35 +++
 rtl/hssaer_rx_arbiter_if.sv | 39 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/hssaer_rx_arbiter.sv | 104 ++++++++++
 tb/tb_hssaer_rx_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hpu_rx_pkg.sv
// Shared constants for the HSSAER RX merge path: default geometry, error
// indices and merged-event field layout.
package hpu_rx_pkg;

  localparam int NCH_DEF       = 4;
  localparam int CHID_W_DEF    = 2;
  localparam int DSIZE_DEF     = 8;
  localparam int INT_DSIZE_DEF = 24;
  localparam int DROP_W_DEF    = 16;

  localparam int ERR_KO  = 0;
  localparam int ERR_RX  = 1;
  localparam int ERR_TO  = 2;
  localparam int ERR_OF  = 3;
  localparam int ERR_NUM = 4;

  // Merged event = {higher_bits, chid, ae}, LSB first.
  localparam int AE_LSB   = 0;
  localparam int CHID_LSB = DSIZE_DEF;
  localparam int HB_LSB   = DSIZE_DEF + CHID_W_DEF;
  localparam int HB_W     = INT_DSIZE_DEF - HB_LSB;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n += {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/hssaer_rx_arbiter_if.sv
// Channel, configuration, status and merged-output signals of the RX arbiter.
// slave = arbiter view, master = surrounding logic / bench view.
interface hssaer_rx_arbiter_if #(
  parameter int NCH       = 4,
  parameter int CHID_W    = 2,
  parameter int DSIZE     = 8,
  parameter int INT_DSIZE = 24,
  parameter int DROP_W    = 16
);
  logic [NCH*DSIZE-1:0]              ch_ae;
  logic [NCH-1:0]                    ch_src_rdy;
  logic [NCH-1:0]                    ch_dst_rdy;
  logic [NCH-1:0]                    ch_err_ko;
  logic [NCH-1:0]                    ch_err_rx;
  logic [NCH-1:0]                    ch_err_to;
  logic [NCH-1:0]                    ch_err_of;
  logic [NCH-1:0]                    cfg_en;
  logic [4*NCH-1:0]                  cfg_err_mask;
  logic [INT_DSIZE-DSIZE-CHID_W-1:0] cfg_higher_bits;
  logic                              err_clr;
  logic [INT_DSIZE-1:0]              out_ae;
  logic                              out_src_rdy;
  logic                              out_dst_rdy;
  logic [4*NCH-1:0]                  err_status;
  logic                              err_irq;
  logic [DROP_W-1:0]                 drop_cnt;

  modport slave (
    input  ch_ae, ch_src_rdy, ch_err_ko, ch_err_rx, ch_err_to, ch_err_of,
    input  cfg_en, cfg_err_mask, cfg_higher_bits, err_clr, out_dst_rdy,
    output ch_dst_rdy, out_ae, out_src_rdy, err_status, err_irq, drop_cnt
  );

  modport master (
    output ch_ae, ch_src_rdy, ch_err_ko, ch_err_rx, ch_err_to, ch_err_of,
    output cfg_en, cfg_err_mask, cfg_higher_bits, err_clr, out_dst_rdy,
    input  ch_dst_rdy, out_ae, out_src_rdy, err_status, err_irq, drop_cnt
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after i_last_gnt, wrapping.
module rr_arbiter #(
  parameter int NCH    = 4,
  parameter int CHID_W = 2
) (
  input  logic [NCH-1:0]    i_req,
  input  logic [CHID_W-1:0] i_last_gnt,
  input  logic              i_enable,
  output logic              o_gnt_valid,
  output logic [CHID_W-1:0] o_gnt_idx,
  output logic [NCH-1:0]    o_gnt_oh
);
  int w_cand;

  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    o_gnt_oh    = '0;
    w_cand      = 0;
    if (i_enable) begin
      for (int k = 1; k <= NCH; k++) begin
        w_cand = int'(i_last_gnt) + k;
        if (w_cand >= NCH) w_cand = w_cand - NCH;
        if (!o_gnt_valid && i_req[w_cand]) begin
          o_gnt_valid      = 1'b1;
          o_gnt_idx        = CHID_W'(w_cand);
          o_gnt_oh[w_cand] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/hssaer_rx_arbiter.sv
// Merges NCH HSSAER RX channels into one tagged event stream through a single
// output register; also keeps sticky error status and a saturating drop count.
module hssaer_rx_arbiter
  import hpu_rx_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int CHID_W    = CHID_W_DEF,
  parameter int DSIZE     = DSIZE_DEF,
  parameter int INT_DSIZE = INT_DSIZE_DEF,
  parameter int DROP_W    = DROP_W_DEF
) (
  input logic               clk,
  input logic               nrst,
  hssaer_rx_arbiter_if.slave bus
);
  out_state_e               r_state;
  out_state_e               w_state_next;
  logic [CHID_W-1:0]        r_last_gnt;
  logic [INT_DSIZE-1:0]     r_out_ae;
  logic [DROP_W-1:0]        r_drop_cnt;
  logic [ERR_NUM*NCH-1:0]   r_err_status;
  logic                     r_err_irq;

  logic [NCH-1:0]           w_req;
  logic [NCH-1:0]           w_flush;
  logic [NCH-1:0]           w_gnt_oh;
  logic                     w_can_load;
  logic                     w_gnt_valid;
  logic [CHID_W-1:0]        w_gnt_idx;
  logic [DSIZE-1:0]         w_gnt_ae;
  logic [ERR_NUM*NCH-1:0]   w_err_level;
  logic [3:0]               w_drop_inc;
  logic [DROP_W:0]          w_drop_sum;
  logic [DROP_W-1:0]        w_drop_next;

  assign w_req      = bus.ch_src_rdy & bus.cfg_en;
  assign w_flush    = bus.ch_src_rdy & ~bus.cfg_en;
  assign w_can_load = (r_state == ST_EMPTY) | bus.out_dst_rdy;

  rr_arbiter #(.NCH(NCH), .CHID_W(CHID_W)) u_rr (
    .i_req       (w_req),
    .i_last_gnt  (r_last_gnt),
    .i_enable    (w_can_load & nrst),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_oh    (w_gnt_oh)
  );

  assign w_gnt_ae       = bus.ch_ae[int'(w_gnt_idx)*DSIZE +: DSIZE];
  // Disabled channels are acknowledged unconditionally so upstream never stalls.
  assign bus.ch_dst_rdy = nrst ? (w_gnt_oh | w_flush) : '0;

  always_comb begin
    w_state_next = r_state;
    if (w_gnt_valid)     w_state_next = ST_FULL;
    else if (w_can_load) w_state_next = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!nrst) r_state <= ST_EMPTY;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_out_ae   <= '0;
      r_last_gnt <= CHID_W'(NCH - 1);
    end else if (w_gnt_valid) begin
      r_out_ae   <= {bus.cfg_higher_bits, w_gnt_idx, w_gnt_ae};
      r_last_gnt <= w_gnt_idx;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_err
    assign w_err_level[ERR_NUM*gi + ERR_KO] = bus.ch_err_ko[gi];
    assign w_err_level[ERR_NUM*gi + ERR_RX] = bus.ch_err_rx[gi];
    assign w_err_level[ERR_NUM*gi + ERR_TO] = bus.ch_err_to[gi];
    assign w_err_level[ERR_NUM*gi + ERR_OF] = bus.ch_err_of[gi];
  end

  assign w_drop_inc  = popcount8(8'(w_flush));
  assign w_drop_sum  = {1'b0, r_drop_cnt} + (DROP_W + 1)'(w_drop_inc);
  assign w_drop_next = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];

  // New error levels are OR-ed after the clear, so a set in the clear cycle survives.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_err_status <= '0;
      r_err_irq    <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_err_status <= (bus.err_clr ? '0 : r_err_status) | w_err_level;
      r_err_irq    <= |(r_err_status & bus.cfg_err_mask);
      r_drop_cnt   <= bus.err_clr ? '0 : w_drop_next;
    end
  end

  assign bus.out_ae      = r_out_ae;
  assign bus.out_src_rdy = (r_state == ST_FULL);
  assign bus.err_status  = r_err_status;
  assign bus.err_irq     = r_err_irq;
  assign bus.drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_hssaer_rx_arbiter.sv
// Randomized and directed bench for hssaer_rx_arbiter against a cycle-level
// reference model built from the arbitration, drop and error rules.
module tb_hssaer_rx_arbiter;
  import hpu_rx_pkg::*;

  localparam int NCH = 4, CHID_W = 2, DSIZE = 8, INT_DSIZE = 24, DROP_W = 16;
  localparam int HBW = INT_DSIZE - DSIZE - CHID_W;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  hssaer_rx_arbiter_if #(.NCH(NCH), .CHID_W(CHID_W), .DSIZE(DSIZE),
                         .INT_DSIZE(INT_DSIZE), .DROP_W(DROP_W)) bus ();

  hssaer_rx_arbiter #(.NCH(NCH), .CHID_W(CHID_W), .DSIZE(DSIZE),
                      .INT_DSIZE(INT_DSIZE), .DROP_W(DROP_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit                   m_full;
  logic [INT_DSIZE-1:0] m_ae;
  int                   m_last;
  int                   m_drop;
  logic [4*NCH-1:0]     m_err;
  bit                   m_irq;
  int                   gnt_log[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.ch_ae           = '0;
    bus.ch_src_rdy      = '0;
    bus.ch_err_ko       = '0;
    bus.ch_err_rx       = '0;
    bus.ch_err_to       = '0;
    bus.ch_err_of       = '0;
    bus.cfg_en          = '1;
    bus.cfg_err_mask    = '0;
    bus.cfg_higher_bits = '0;
    bus.err_clr         = 1'b0;
    bus.out_dst_rdy     = 1'b1;
  endtask

  task automatic drive_rand();
    nrst                = ($urandom_range(99) != 0);
    bus.ch_ae           = NCH*DSIZE'($urandom);
    bus.ch_src_rdy      = NCH'($urandom);
    bus.cfg_en          = ($urandom_range(3) == 0) ? NCH'($urandom) : '1;
    bus.ch_err_ko       = ($urandom_range(15) == 0) ? NCH'($urandom) : '0;
    bus.ch_err_rx       = ($urandom_range(15) == 0) ? NCH'($urandom) : '0;
    bus.ch_err_to       = ($urandom_range(15) == 0) ? NCH'($urandom) : '0;
    bus.ch_err_of       = ($urandom_range(15) == 0) ? NCH'($urandom) : '0;
    bus.cfg_err_mask    = 16'($urandom);
    bus.cfg_higher_bits = HBW'($urandom);
    bus.err_clr         = ($urandom_range(19) == 0);
    bus.out_dst_rdy     = ($urandom_range(3) != 0);
  endtask

  // Called just after a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    logic [NCH-1:0]       req, flush, exp_dst;
    logic [4*NCH-1:0]     lev, n_err;
    logic [INT_DSIZE-1:0] n_ae;
    bit                   can, n_full, n_irq;
    int                   g, n_drop, n_last, sum;
    #1;
    req   = bus.ch_src_rdy & bus.cfg_en;
    flush = bus.ch_src_rdy & ~bus.cfg_en;
    can   = !m_full || bus.out_dst_rdy;
    g     = -1;
    if (nrst && can)
      for (int k = 1; k <= NCH; k++)
        if (g < 0 && req[(m_last + k) % NCH]) g = (m_last + k) % NCH;
    exp_dst = '0;
    if (nrst) begin
      exp_dst = flush;
      if (g >= 0) exp_dst[g] = 1'b1;
    end
    chk("ch_dst_rdy", bus.ch_dst_rdy, exp_dst);
    if (nrst && m_full && bus.out_dst_rdy)
      $display("xfer: ch=%0d ae=0x%06h", m_ae[DSIZE +: CHID_W], m_ae);

    for (int c = 0; c < NCH; c++) begin
      lev[4*c + ERR_KO] = bus.ch_err_ko[c];
      lev[4*c + ERR_RX] = bus.ch_err_rx[c];
      lev[4*c + ERR_TO] = bus.ch_err_to[c];
      lev[4*c + ERR_OF] = bus.ch_err_of[c];
    end

    if (!nrst) begin
      n_full = 1'b0; n_ae = '0; n_last = NCH - 1;
      n_drop = 0;    n_err = '0; n_irq = 1'b0;
    end else begin
      n_full = m_full; n_ae = m_ae; n_last = m_last;
      if (g >= 0) begin
        n_full = 1'b1;
        n_ae   = {bus.cfg_higher_bits, CHID_W'(g), bus.ch_ae[g*DSIZE +: DSIZE]};
        n_last = g;
      end else if (can) begin
        n_full = 1'b0;
      end
      sum    = m_drop + $countones(flush);
      n_drop = bus.err_clr ? 0 : ((sum > 65535) ? 65535 : sum);
      n_err  = (bus.err_clr ? '0 : m_err) | lev;
      n_irq  = |(m_err & bus.cfg_err_mask);
    end
    if (g >= 0) gnt_log.push_back(g);

    @(posedge clk);
    #1;
    m_full = n_full; m_ae = n_ae; m_last = n_last;
    m_drop = n_drop; m_err = n_err; m_irq = n_irq;
    chk("out_src_rdy", bus.out_src_rdy, m_full);
    if (m_full || !nrst) chk("out_ae", bus.out_ae, m_ae);
    chk("drop_cnt", bus.drop_cnt, m_drop);
    chk("err_status", bus.err_status, m_err);
    chk("err_irq", bus.err_irq, m_irq);
    @(negedge clk);
  endtask

  logic [INT_DSIZE-1:0] held;
  logic [HBW-1:0]       hb;

  initial begin
    m_full = 1'b0; m_ae = '0; m_last = NCH - 1; m_drop = 0; m_err = '0; m_irq = 1'b0;
    drive_idle();
    nrst = 1'b0;
    @(negedge clk);

    // Reset
    repeat (2) cycle();
    chk("reset_src_rdy", bus.out_src_rdy, 0);
    chk("reset_out_ae", bus.out_ae, 0);
    chk("reset_drop", bus.drop_cnt, 0);

    // Single event on channel 2
    nrst = 1'b1;
    bus.cfg_higher_bits = 14'h3A5;
    bus.ch_src_rdy      = 4'b0100;
    bus.ch_ae           = 32'h005A_0000;
    cycle();
    chk("single_ae", bus.out_ae, 24'h0E965A);
    chk("single_vld", bus.out_src_rdy, 1);
    bus.ch_src_rdy = '0;
    cycle();
    chk("single_drain", bus.out_src_rdy, 0);

    // Fairness after a fresh reset
    nrst = 1'b0;
    cycle();
    nrst = 1'b1;
    gnt_log.delete();
    bus.ch_src_rdy = '1;
    for (int k = 0; k < 8; k++) begin
      bus.ch_ae = 32'($urandom);
      cycle();
    end
    chk("fair_count", gnt_log.size(), 8);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("fair_order", gnt_log[k], k % NCH);

    // Backpressure with channel 1 waiting
    bus.ch_src_rdy  = 4'b0010;
    bus.ch_ae       = 32'h0000_1100;
    bus.out_dst_rdy = 1'b0;
    hb              = bus.cfg_higher_bits;
    held            = bus.out_ae;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_hold", bus.out_ae, held);
    end
    bus.out_dst_rdy = 1'b1;
    cycle();
    chk("bp_accept", bus.out_ae, {hb, 2'd1, 8'h11});

    // Reset while FULL, then channels 3 and 0 contend
    bus.out_dst_rdy = 1'b0;
    bus.ch_src_rdy  = 4'b1001;
    nrst            = 1'b0;
    cycle();
    chk("rst_mid_src_rdy", bus.out_src_rdy, 0);
    nrst = 1'b1;
    bus.out_dst_rdy = 1'b1;
    gnt_log.delete();
    cycle();
    chk("rst_gnt_count", gnt_log.size(), 1);
    if (gnt_log.size() > 0) chk("rst_first_gnt", gnt_log[0], 0);

    // Error capture, irq latency and clear priority
    drive_idle();
    bus.cfg_err_mask = 16'h4000;
    bus.ch_err_to    = 4'b1000;
    cycle();
    chk("err_set", bus.err_status[14], 1);
    bus.ch_err_to = '0;
    cycle();
    chk("err_irq_up", bus.err_irq, 1);
    bus.err_clr = 1'b1;
    cycle();
    chk("err_cleared", bus.err_status[14], 0);
    bus.err_clr = 1'b0;
    cycle();
    chk("err_irq_down", bus.err_irq, 0);
    bus.err_clr   = 1'b1;
    bus.ch_err_to = 4'b1000;
    cycle();
    chk("err_set_wins", bus.err_status[14], 1);
    drive_idle();
    cycle();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      drive_rand();
      cycle();
    end

    // Disabled channel flooding past drop counter saturation
    drive_idle();
    nrst = 1'b0;
    cycle();
    nrst           = 1'b1;
    bus.cfg_en     = 4'b1110;
    bus.ch_src_rdy = 4'b0001;
    repeat (70000) begin
      bus.ch_ae = 32'($urandom);
      cycle();
    end
    chk("drop_sat", bus.drop_cnt, 16'hFFFF);
    bus.ch_src_rdy = '0;
    bus.err_clr    = 1'b1;
    cycle();
    chk("drop_clr", bus.drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
